uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_tx_serializer.sv | 75 +++++++
 rtl/uart_tx_arbiter.sv | 109 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// serializer state encoding, the LF terminator byte and the baud divisor helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] LF = 8'h0A;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: loads a byte when idle or in the last stop-bit cycle and
// shifts it out LSB-first, each bit held DIV clocks. txd is registered.
module uart_tx_serializer
  import uart_arb_pkg::*;
#(
  parameter int unsigned DIV = 50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_busy,
  output logic       o_last_cycle,
  output logic       o_txd
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          w_bit_end;
  logic          w_load;

  assign w_bit_end    = (r_cnt == CW'(DIV - 1));
  assign o_busy       = (r_state != IDLE);
  assign o_last_cycle = (r_state == STOP) && w_bit_end;
  assign w_load       = i_load && (!o_busy || o_last_cycle);
  assign o_txd        = r_txd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_load) w_state_next = START;
      START: if (w_bit_end) w_state_next = DATA;
      DATA:  if (w_bit_end && (r_bit == 3'd7)) w_state_next = STOP;
      STOP:  if (w_bit_end) w_state_next = w_load ? START : IDLE;
    endcase
  end

  // Bit timing and line driver; a mid-frame reset drops the frame and idles the line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_bit <= 3'd0;
      r_txd <= 1'b1;
    end else begin
      r_cnt <= ((r_state == IDLE) || w_bit_end) ? '0 : r_cnt + 1'b1;
      if ((r_state == DATA) && w_bit_end) r_bit <= r_bit + 3'd1;
      if (w_load) begin
        r_txd <= 1'b0;
      end else if (w_bit_end) begin
        unique case (r_state)
          START:   r_txd <= r_shift[0];
          DATA:    r_txd <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
          default: r_txd <= 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load)                               r_shift <= i_byte;
    else if ((r_state == DATA) && w_bit_end)  r_shift <= {1'b0, r_shift[7:1]};
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding two byte requesters onto one UART TX line.
// Define UART_ARB_LINE_LOCK_EN to hold the line for one owner until it sends LF or idles LOCK_TIMEOUT cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 1000000,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req0_data_i,
  input  logic [7:0] req1_data_i,
  input  logic       req0_valid_i,
  input  logic       req1_valid_i,
  output logic       req0_accept_o,
  output logic       req1_accept_o,
  output logic       txd_o,
  output logic       busy_o,
  output logic [1:0] grant_o
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

  generate
    if (DIV < 2 || LOCK_TIMEOUT < 1) begin : g_bad_cfg
      $error("uart_tx_arbiter: CLK_FREQ/BAUD must be >= 2 and LOCK_TIMEOUT >= 1");
    end
  endgenerate

  logic       r_ptr;
  logic [1:0] r_grant;
  logic       w_v0;
  logic       w_v1;
  logic       w_ready;
  logic       w_sel1;
  logic       w_take;
  logic       w_ser_busy;
  logic       w_ser_last;
  logic [7:0] w_byte;

  // Arbitrate only while the serializer can take a byte on the coming edge.
  assign w_ready       = !w_ser_busy || w_ser_last;
  assign w_sel1        = w_v1 && (!w_v0 || r_ptr);
  assign w_take        = w_ready && (w_v0 || w_v1) && !rst_i;
  assign req0_accept_o = w_take && !w_sel1;
  assign req1_accept_o = w_take && w_sel1;
  assign w_byte        = w_sel1 ? req1_data_i : req0_data_i;
  assign busy_o        = w_ser_busy;
  assign grant_o       = r_grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr   <= 1'b0;
      r_grant <= 2'b00;
    end else if (w_take) begin
      r_ptr   <= !w_sel1;
      r_grant <= w_sel1 ? 2'b10 : 2'b01;
    end
  end

`ifdef UART_ARB_LINE_LOCK_EN
  localparam int unsigned IW = $clog2(LOCK_TIMEOUT + 1);

  logic          r_lock;
  logic [IW-1:0] r_idle;
  logic          w_owner_vld;
  logic          w_timeout;
  logic          w_locked;

  // The timeout releases the lock combinationally so the waiting side is served in that cycle.
  assign w_owner_vld = r_grant[1] ? req1_valid_i : req0_valid_i;
  assign w_timeout   = r_lock && !w_owner_vld && (r_idle == IW'(LOCK_TIMEOUT - 1));
  assign w_locked    = r_lock && !w_timeout;
  assign w_v0        = req0_valid_i && (!w_locked || r_grant[0]);
  assign w_v1        = req1_valid_i && (!w_locked || r_grant[1]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock <= 1'b0;
      r_idle <= '0;
    end else if (w_take) begin
      r_lock <= (w_byte != LF);
      r_idle <= '0;
    end else if (w_timeout || !r_lock || w_owner_vld) begin
      if (w_timeout) r_lock <= 1'b0;
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_v0 = req0_valid_i;
  assign w_v1 = req1_valid_i;
`endif

  uart_tx_serializer #(
    .DIV (DIV)
  ) u_ser (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_load       (w_take),
    .i_byte       (w_byte),
    .o_busy       (w_ser_busy),
    .o_last_cycle (w_ser_last),
    .o_txd        (txd_o)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter at DIV=50: a line decoder captures frames and a
// queue-level arbitration model predicts the byte order (UART_ARB_LINE_LOCK_EN aware).
module tb_uart_tx_arbiter;

  localparam int DIV   = 50;
  localparam int FRAME = 10 * DIV;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0] b;
    int         t;
    bit         stop_ok;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r0d = 8'h00;
  logic [7:0] r1d = 8'h00;
  logic       r0v = 1'b0;
  logic       r1v = 1'b0;
  logic       acc0, acc1, txd, busy;
  logic [1:0] grant;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dual_acc = 0;
  int drv_timeouts = 0;
  bit mon_en = 1'b0;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];
  bit         tmo_q[$];

  uart_tx_arbiter #(
    .CLK_FREQ(50000000), .BAUD(1000000), .LOCK_TIMEOUT(1024)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_data_i(r0d), .req1_data_i(r1d),
    .req0_valid_i(r0v), .req1_valid_i(r1v),
    .req0_accept_o(acc0), .req1_accept_o(acc1),
    .txd_o(txd), .busy_o(busy), .grant_o(grant)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (acc0 && acc1) dual_acc <= dual_acc + 1;

  // Line decoder: samples each bit in its middle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        frame_t f;
        f.t = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          f.b[i] = txd;
        end
        repeat (DIV) @(negedge clk);
        f.stop_ok = (txd === 1'b1);
        rx_q.push_back(f);
      end
    end
  end

  // Expected line order from the arbitration rules, plus which frames follow a lock timeout.
  function automatic void model(input byte_q_t q0, input byte_q_t q1);
    int i0 = 0;
    int i1 = 0;
    bit ptr = 1'b0;
    bit lock = 1'b0;
    bit own = 1'b0;
    bit pend_tmo = 1'b0;
    exp_q.delete();
    tmo_q.delete();
    while (i0 < q0.size() || i1 < q1.size()) begin
      bit h0, h1, who;
      logic [7:0] b;
      h0 = (i0 < q0.size());
      h1 = (i1 < q1.size());
      if (lock && !(own ? h1 : h0)) begin
        lock = 1'b0;
        pend_tmo = 1'b1;
      end
      if (lock)          who = own;
      else if (h0 && h1) who = ptr;
      else               who = h1;
      if (who) begin b = q1[i1]; i1++; end
      else     begin b = q0[i0]; i0++; end
      exp_q.push_back(b);
      tmo_q.push_back(pend_tmo);
      pend_tmo = 1'b0;
      ptr = !who;
`ifdef UART_ARB_LINE_LOCK_EN
      lock = (b != 8'h0A);
      own = who;
`endif
    end
  endfunction

  task automatic drive(input int which, input byte_q_t q);
    for (int i = 0; i < q.size(); i++) begin
      int k;
      k = 0;
      if (which == 0) begin r0d = q[i]; r0v = 1'b1; end
      else            begin r1d = q[i]; r1v = 1'b1; end
      do begin
        @(negedge clk);
        k++;
      end while (!((which == 0) ? acc0 : acc1) && k < 20000);
      if (k >= 20000) drv_timeouts++;
      @(posedge clk); #1;
    end
    if (which == 0) r0v = 1'b0;
    else            r1v = 1'b0;
  endtask

  // Reset, then both requesters present their queues from the first cycle out of reset.
  task automatic run_seq(input byte_q_t q0, input byte_q_t q1);
    int n;
    rst = 1'b1; r0v = 1'b0; r1v = 1'b0; drv_timeouts = 0;
    @(posedge clk); #1;
    rx_q.delete();
    mon_en = 1'b1;
    fork
      drive(0, q0);
      drive(1, q1);
      begin @(posedge clk); #1; rst = 1'b0; end
    join
    n = 0;
    while (rx_q.size() < q0.size() + q1.size() && n < 30000) begin
      @(negedge clk);
      n++;
    end
    repeat (DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; r0v = 1'b1; r1v = 1'b1; r0d = 8'h12; r1d = 8'h34;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (acc0 !== 1'b0 || acc1 !== 1'b0) begin errors++; $display("FAIL reset_accept got %b%b exp 00", acc1, acc0); end
    @(posedge clk); #1;
    r0v = 1'b0; r1v = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    int n, pulses, other;
    int bad[10];
    logic e;
    d = 8'h55;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    r0d = d; r0v = 1'b1;
    n = 0;
    @(negedge clk);
    while (!acc0 && n < 200) begin @(negedge clk); n++; end
    checks++; if (acc0 !== 1'b1 || acc1 !== 1'b0) begin errors++; $display("FAIL single_accept got %b%b exp 01", acc1, acc0); end
    @(posedge clk); #1; r0v = 1'b0;
    @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL single_start_edge got %b exp 0", txd); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", grant); end
    pulses = 0; other = 0;
    for (int k = 0; k < 10; k++) bad[k] = 0;
    for (int i = 0; i < FRAME; i++) begin
      int k;
      if (i > 0) @(negedge clk);
      k = i / DIV;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
      if (txd !== e || busy !== 1'b1) bad[k]++;
      if (acc0) pulses++;
      if (acc1) other++;
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bad[k] != 0) begin errors++; $display("FAIL single_bit%0d got %0d wrong cycles exp 0", k, bad[k]); end
    end
    checks++; if (pulses != 0 || other != 0) begin errors++; $display("FAIL single_extra_accept got %0d/%0d exp 0/0", pulses, other); end
    @(negedge clk);
    checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_end got txd %b busy %b exp 1 0", txd, busy); end
  endtask

  task automatic test_contention();
    byte_q_t q0, q1;
    int d0;
    q0 = '{8'h41, 8'h41};
    q1 = '{8'h42, 8'h42};
    model(q0, q1);
    d0 = dual_acc;
    run_seq(q0, q1);
    checks++; if (dual_acc != d0 || drv_timeouts != 0) begin errors++; $display("FAIL cont_handshake got dual %0d timeouts %0d exp 0 0", dual_acc - d0, drv_timeouts); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL cont_count got %0d exp %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i].b !== exp_q[i] || !rx_q[i].stop_ok) begin errors++; $display("FAIL cont_byte%0d got %h stop %0b exp %h", i, rx_q[i].b, rx_q[i].stop_ok, exp_q[i]); end
      if (i > 0 && !tmo_q[i]) begin
        checks++;
        if (rx_q[i].t - rx_q[i-1].t != FRAME) begin errors++; $display("FAIL cont_gap%0d got %0d exp %0d", i, rx_q[i].t - rx_q[i-1].t, FRAME); end
      end
    end
  endtask

  task automatic test_line_lock();
    byte_q_t q0, q1;
    q0 = '{8'h41, 8'h42, 8'h0A};
    q1 = '{8'h5A, 8'h5A};
    model(q0, q1);
    run_seq(q0, q1);
    checks++; if (rx_q.size() != exp_q.size() || drv_timeouts != 0) begin errors++; $display("FAIL lock_count got %0d exp %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i].b !== exp_q[i] || !rx_q[i].stop_ok) begin errors++; $display("FAIL lock_byte%0d got %h exp %h", i, rx_q[i].b, exp_q[i]); end
    end
  endtask

`ifdef UART_ARB_LINE_LOCK_EN
  task automatic test_lock_timeout();
    int n, hit;
    rst = 1'b1;
    @(posedge clk); #1;
    r0d = 8'h41; r0v = 1'b1; r1d = 8'h5A; r1v = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(acc0 || acc1) && n < 200) begin @(negedge clk); n++; end
    checks++; if (acc0 !== 1'b1 || acc1 !== 1'b0) begin errors++; $display("FAIL tmo_first got %b%b exp 01", acc1, acc0); end
    @(posedge clk); #1; r0v = 1'b0;
    hit = -1;
    for (int k = 1; k <= 1200 && hit < 0; k++) begin
      @(negedge clk);
      if (acc1) hit = k;
    end
    checks++; if (hit != 1024) begin errors++; $display("FAIL tmo_release got idle cycle %0d exp 1024", hit); end
    @(posedge clk); #1; r1v = 1'b0;
    repeat (FRAME + DIV) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_frame();
    byte_q_t q0, q1;
    int n, bad;
    logic [1:0] first;
    mon_en = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    r0d = 8'h00; r0v = 1'b1;
    n = 0;
    @(negedge clk);
    while (!acc0 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1; r0v = 1'b0;
    @(negedge clk);
    repeat (230) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL mid_pre_reset got %b exp 0", txd); end
    rst = 1'b1; #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_txd_async got %b exp 1", txd); end
    checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL mid_state got busy %b grant %b exp 0 00", busy, grant); end
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_resume got %0d active cycles exp 0", bad); end
    @(posedge clk); #1;
    rx_q.delete(); mon_en = 1'b1; drv_timeouts = 0;
    q0 = '{8'h33};
    q1 = '{8'h66};
    first = 2'b00;
    fork
      drive(0, q0);
      drive(1, q1);
      begin
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!(acc0 || acc1) && k < 200);
        first = {acc1, acc0};
      end
    join
    checks++; if (first !== 2'b01) begin errors++; $display("FAIL mid_next_grant got %b exp 01", first); end
    n = 0;
    while (rx_q.size() < 2 && n < 5000) begin @(negedge clk); n++; end
    repeat (DIV) @(negedge clk);
    checks++;
    if (rx_q.size() != 2 || drv_timeouts != 0) begin
      errors++; $display("FAIL mid_frames got %0d exp 2", rx_q.size());
    end else if (rx_q[0].b !== 8'h33 || rx_q[1].b !== 8'h66 || !rx_q[0].stop_ok) begin
      errors++; $display("FAIL mid_frames got %h %h exp 33 66", rx_q[0].b, rx_q[1].b);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      byte_q_t q0, q1;
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
      for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
      q0.push_back(8'h0A);
      q1.push_back(8'h0A);
      model(q0, q1);
      run_seq(q0, q1);
      checks++; if (rx_q.size() != exp_q.size() || drv_timeouts != 0) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", r, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i].b !== exp_q[i] || !rx_q[i].stop_ok) begin errors++; $display("FAIL rand%0d_byte%0d got %h exp %h", r, i, rx_q[i].b, exp_q[i]); end
        if (i > 0 && !tmo_q[i]) begin
          checks++;
          if (rx_q[i].t - rx_q[i-1].t != FRAME) begin errors++; $display("FAIL rand%0d_gap%0d got %0d exp %0d", r, i, rx_q[i].t - rx_q[i-1].t, FRAME); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_contention();
    test_line_lock();
`ifdef UART_ARB_LINE_LOCK_EN
    test_lock_timeout();
`endif
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
